// File: rtl/regfile_writer_if.sv
// Write-request handshake between a producer and the register-file writer.
interface regfile_writer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_writer.sv
// Register-file writer: sweeps default values into every register after reset or on request,
// then drains a small FIFO of queued write requests one per cycle.
module regfile_writer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  regfile_writer_if.slave              req,
  input  logic                         init_start,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        w_addr,
  output logic [DATA_WIDTH-1:0]        w_data,
  output logic                         init_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned EntW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  init_done_q, init_done_d;
  logic [EntW-1:0]       mem [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic [EntW-1:0] head;

  assign req.req_ready = rst_n && (level_q != LvlW'(FIFO_DEPTH));
  assign push          = req.req_valid && req.req_ready;
  // The init_start edge itself does not pop: queued entries wait for the sweep to finish.
  assign pop           = (state_q == StRun) && !init_start && (level_q != '0);
  assign head          = mem[rptr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    init_done_d = init_done_q;

    unique case (state_q)
      StInit: begin
        wr_en_d     = 1'b1;
        w_addr_d    = cnt_q;
        w_data_d    = (32'(cnt_q) == 32'd6) ? '1 : '0;
        cnt_d       = cnt_q + 1'b1;
        init_done_d = 1'b0;
        if (cnt_q == '1) begin
          state_d = StRun;
        end
      end
      StRun: begin
        init_done_d = 1'b1;
        if (init_start) begin
          state_d     = StInit;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (pop) begin
          wr_en_d  = 1'b1;
          w_addr_d = head[EntW-1:DATA_WIDTH];
          w_data_d = head[DATA_WIDTH-1:0];
        end
      end
      default: state_d = StInit;
    endcase

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q + LvlW'(push) - LvlW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      wr_en_q     <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      wr_en_q     <= wr_en_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage needs no reset; push is gated by req_ready, which is low during reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= {req.req_addr, req.req_data};
    end
  end

  assign wr_en      = wr_en_q;
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign init_done  = init_done_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Directed and randomized bench for regfile_writer against a queue-based transaction model.
module tb_regfile_writer;

  logic       clk;
  logic       rst_n;
  logic       init_start;
  logic       wr_en;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic       init_done;
  logic [2:0] fifo_level;

  regfile_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) rq ();

  regfile_writer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (rq),
    .init_start (init_start),
    .wr_en      (wr_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .init_done  (init_done),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending requests as a queue, sweep position, visible outputs.
  logic [10:0] m_q[$];
  bit          m_init;
  int          m_idx;
  logic        m_wr;
  logic [2:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_done;
  logic        acc_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] a, input logic [7:0] d,
                      input logic st, input logic rn);
    logic [10:0] e;
    bit          full;
    rq.req_valid = v;
    rq.req_addr  = a;
    rq.req_data  = d;
    init_start   = st;
    rst_n        = rn;
    #1;
    full = (m_q.size() == 4);
    chk("req_ready", 32'(rq.req_ready), 32'(rn && !full));
    acc_last = rn && v && !full;

    if (!rn) begin
      m_q.delete();
      m_init = 1'b1;
      m_idx  = 0;
      m_wr   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_done = 1'b0;
    end else begin
      if (m_init) begin
        m_wr   = 1'b1;
        m_addr = m_idx[2:0];
        m_data = (m_idx == 6) ? 8'hFF : 8'h00;
        m_done = 1'b0;
        m_idx++;
        if (m_idx == 8) m_init = 1'b0;
      end else if (st) begin
        m_init = 1'b1;
        m_idx  = 0;
        m_done = 1'b0;
        m_wr   = 1'b0;
      end else begin
        m_done = 1'b1;
        if (m_q.size() > 0) begin
          e      = m_q.pop_front();
          m_wr   = 1'b1;
          m_addr = e[10:8];
          m_data = e[7:0];
        end else begin
          m_wr = 1'b0;
        end
      end
      if (acc_last) m_q.push_back({a, d});
    end

    @(posedge clk);
    #1;
    chk("wr_en", 32'(wr_en), 32'(m_wr));
    chk("w_addr", 32'(w_addr), 32'(m_addr));
    chk("w_data", 32'(w_data), 32'(m_data));
    chk("init_done", 32'(init_done), 32'(m_done));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
  endtask

  logic [2:0] l_addr [6];
  logic [7:0] l_data [6];

  initial begin
    int k;
    rq.req_valid = 1'b0;
    rq.req_addr  = '0;
    rq.req_data  = '0;
    init_start   = 1'b0;
    rst_n        = 1'b0;
    acc_last     = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then the power-up sweep and settle into RUN.
    step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h11, 1'b0, 1'b0);
    idle(10);

    // Two back-to-back requests in RUN.
    step(1'b1, 3'd3, 8'hA5, 1'b0, 1'b1);
    step(1'b1, 3'd5, 8'h3C, 1'b0, 1'b1);
    idle(3);

    // Six requests held valid during INIT; backpressure after four.
    for (int i = 0; i < 6; i++) begin
      l_addr[i] = 3'($urandom_range(0, 7));
      l_data[i] = 8'($urandom);
    end
    step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      step(1'b1, l_addr[k], l_data[k], 1'b0, 1'b1);
      if (acc_last) k++;
    end
    idle(6);

    // Re-initialisation with two entries queued.
    step(1'b1, 3'd2, 8'h5A, 1'b0, 1'b1);
    step(1'b1, 3'd4, 8'hC3, 1'b1, 1'b1);
    idle(12);

    // Reset mid-sweep with three entries queued; they must never appear.
    step(1'b0, 3'd0, 8'd0, 1'b1, 1'b1);
    step(1'b1, 3'd1, 8'h77, 1'b0, 1'b1);
    step(1'b1, 3'd6, 8'h88, 1'b0, 1'b1);
    step(1'b1, 3'd7, 8'h99, 1'b0, 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    idle(12);

    // Random traffic with occasional re-init and reset.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) != 0));
    end
    idle(14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_writer.md
REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, register address width (2**ADDR_WIDTH registers).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, write-request queue depth (power of two).
REQ-004 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port req_valid  input  1  producer has a write request.
REQ-007 The block SHALL have port req_addr  input  ADDR_WIDTH  target register of the request.
REQ-008 The block SHALL have port req_data  input  DATA_WIDTH  data of the request.
REQ-009 The block SHALL have port req_ready  output  1  queue can accept a request.
REQ-010 The block SHALL have port init_start  input  1  one-cycle pulse requesting re-initialisation.
REQ-011 The block SHALL have port wr_en  output  1  register-file write enable (bank_wr_en).
REQ-012 The block SHALL have port w_addr  output  ADDR_WIDTH  register-file write address (BusC_addr).
REQ-013 The block SHALL have port w_data  output  DATA_WIDTH  register-file write data.
REQ-014 The block SHALL have port init_done  output  1  initialisation sweep complete.
REQ-015 The block SHALL have port fifo_level  output  log2(FIFO_DEPTH)+1  queue occupancy.

Function
REQ-016 The block SHALL implement a two-state FSM: INIT and RUN.
REQ-017 In INIT, a counter SHALL step 0 to 2**ADDR_WIDTH-1, one address per cycle, each cycle driving wr_en=1, w_addr=counter, w_data=all-ones for address 6, otherwise 0.
REQ-018 After the write of the last address, the FSM SHALL enter RUN and init_done SHALL be 1 from the next cycle; an INIT sweep lasts exactly 2**ADDR_WIDTH cycles.
REQ-019 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_ready SHALL equal (fifo_level != FIFO_DEPTH) and SHALL be 0 while rst_n=0.
REQ-020 Requests SHALL be accepted in both INIT and RUN; the queue SHALL drain only in RUN.
REQ-021 In RUN, on each edge with the queue non-empty, the head entry SHALL be popped and registered onto w_addr/w_data with wr_en=1 for one cycle; otherwise wr_en SHALL be 0 and w_addr/w_data SHALL hold.
REQ-022 Latency: a request accepted at edge N into an empty queue in RUN SHALL drive wr_en=1 in the cycle after edge N+1; sustained throughput SHALL be one write per cycle.
REQ-023 Writes SHALL leave in acceptance order; no coalescing or reordering.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged; push when full SHALL be impossible (req_ready=0).
REQ-025 An init_start pulse in RUN SHALL clear init_done, reset the counter to 0 and enter INIT on the next edge; queue contents SHALL be preserved and draining paused until RUN.
REQ-026 init_start SHALL be ignored while in INIT.
REQ-027 wr_en, w_addr, w_data, init_done SHALL be registered outputs.

Reset
REQ-028 On a rising edge with rst_n=0: FSM to INIT, counter 0, queue flushed (fifo_level 0), wr_en 0, w_addr 0, w_data 0, init_done 0.
REQ-029 Reset asserted mid-sweep or mid-drain SHALL discard all queued requests and restart the full sweep from address 0 after rst_n rises.

Verification
REQ-030 Release reset -> wr_en=1 for 8 consecutive cycles, w_addr 0..7, w_data 0x00 except 0xFF at address 6; init_done=1 on the 9th cycle.
REQ-031 In RUN, push (3,0xA5) then (5,0x3C) back-to-back -> wr_en=1 two consecutive cycles with (3,0xA5) then (5,0x3C), first one cycle after the edge following acceptance.
REQ-032 Push 6 requests during INIT with req_valid held -> req_ready drops after 4 accepted, fifo_level=4; entries drain in order after init_done, remaining 2 then accepted.
REQ-033 init_start while 2 entries are queued in RUN -> 8-cycle sweep rewrites defaults, queued entries written afterwards, fifo_level returns to 0.
REQ-034 rst_n=0 for one cycle with 3 entries queued -> fifo_level=0, wr_en=0, init_done=0, full sweep restarts; flushed entries are never written.
